// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle carrying a control field and a data field between two pipeline stages.
// The master drives valid/ctrl/data and the slave returns ready.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 101
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer, registered in_ready, flush and bubble ctrl gating.
// Optional saturating stall/bubble counters are enabled by defining PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 101,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Bit 1 is main_v and bit 0 is skid_v, so the outputs read straight off the state.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  state_t            state_q;
  logic              in_rdy_q;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic main_v;
  logic in_fire;
  logic out_fire;

  assign main_v   = state_q[1];
  assign in_fire  = up.valid & in_rdy_q;
  assign out_fire = main_v & dn.ready;

  assign up.ready = in_rdy_q;
  assign dn.valid = main_v;
  assign dn.ctrl  = main_ctrl;
  assign dn.data  = main_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      in_rdy_q  <= 1'b1;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state_q   <= EMPTY;
      in_rdy_q  <= 1'b1;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q   <= ONE;
            main_ctrl <= up.ctrl;
            main_data <= up.data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl <= up.ctrl;
            main_data <= up.data;
          end else if (in_fire) begin
            // Downstream stalled: park the new entry and drop ready for next cycle.
            state_q   <= TWO;
            skid_ctrl <= up.ctrl;
            skid_data <= up.data;
            in_rdy_q  <= 1'b0;
          end else if (out_fire) begin
            state_q   <= EMPTY;
            main_ctrl <= '0;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_q   <= ONE;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            skid_ctrl <= '0;
            in_rdy_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= EMPTY;
          in_rdy_q  <= 1'b1;
          main_ctrl <= '0;
          skid_ctrl <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_REG_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (main_v && !dn.ready) stall_q  <= sat_inc(stall_q);
      if (!main_v && dn.ready) bubble_q <= sat_inc(bubble_q);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, hand sequences for multi-cycle corners,
// and randomized traffic checked against a queue-based reference model.
module tb_pipe_stage_reg;
  localparam int CTRL_W = 8;
  localparam int DATA_W = 101;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up ();
  pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn ();

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .up         (up),
    .dn         (dn),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Reference model: the register is just an ordered list of at most two held entries.
  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t        mq[$];
  bit          m_rdy = 1'b1;
  int unsigned m_stall = 0;
  int unsigned m_bubble = 0;

  task automatic model_reset();
    mq.delete();
    m_rdy    = 1'b1;
    m_stall  = 0;
    m_bubble = 0;
  endtask

  task automatic model_edge(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                            input logic ordy, input logic fl);
    bit ov;
    bit acc;
    ov  = (mq.size() > 0);
    acc = v && m_rdy;
    if (ov && !ordy) m_stall++;
    if (!ov && ordy) m_bubble++;
    if (fl) begin
      mq.delete();
      m_rdy = 1'b1;
    end else begin
      if (ov && ordy) void'(mq.pop_front());
      if (acc) mq.push_back('{c: c, d: d});
      m_rdy = (mq.size() < 2);
    end
  endtask

  // Drive inputs, take one clock edge, and leave time 1 unit after the edge for sampling.
  task automatic cycle(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic fl);
    up.valid = v;
    up.ctrl  = c;
    up.data  = d;
    dn.ready = ordy;
    flush    = fl;
    @(posedge clk);
    model_edge(v, c, d, ordy, fl);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [CTRL_W-1:0] ec;
    ec = (mq.size() > 0) ? mq[0].c : '0;
    check({tag, ".out_valid"}, 128'(dn.valid), 128'(mq.size() > 0));
    check({tag, ".in_ready"},  128'(up.ready), 128'(m_rdy));
    check({tag, ".out_ctrl"},  128'(dn.ctrl),  128'(ec));
    if (mq.size() > 0) check({tag, ".out_data"}, 128'(dn.data), 128'(mq[0].d));
`ifdef PIPE_STAGE_REG_PERF_EN
    check({tag, ".stall_cnt"},  128'(stall_cnt),  128'(m_stall));
    check({tag, ".bubble_cnt"}, 128'(bubble_cnt), 128'(m_bubble));
`else
    check({tag, ".stall_cnt"},  128'(stall_cnt),  128'(0));
    check({tag, ".bubble_cnt"}, 128'(bubble_cnt), 128'(0));
`endif
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DATA_W-1:0];
  endfunction

  typedef struct {
    logic              v;
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic              ordy;
    logic              fl;
    logic              ev;
    logic [CTRL_W-1:0] ec;
    logic [DATA_W-1:0] ed;
    logic              erdy;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                              input logic ordy, input logic fl, input logic ev,
                              input logic [CTRL_W-1:0] ec, input logic [DATA_W-1:0] ed, input logic erdy);
    vec_t r;
    r.v = v; r.c = c; r.d = d; r.ordy = ordy; r.fl = fl;
    r.ev = ev; r.ec = ec; r.ed = ed; r.erdy = erdy;
    return r;
  endfunction

  vec_t tbl[18];

  initial begin
    // Columns: in_valid, in_ctrl, in_data, out_ready, flush -> out_valid, out_ctrl, out_data, in_ready
    tbl[0]  = mk(1, 8'h05, 101'h1234, 1, 0, 1, 8'h05, 101'h1234, 1);
    tbl[1]  = mk(0, 8'h00, 101'h0,    1, 0, 0, 8'h00, 101'h0,    1);
    tbl[2]  = mk(0, 8'h77, 101'h9,    1, 0, 0, 8'h00, 101'h0,    1);
    tbl[3]  = mk(0, 8'h88, 101'h8,    1, 0, 0, 8'h00, 101'h0,    1);
    tbl[4]  = mk(1, 8'hA1, 101'hAAA,  0, 0, 1, 8'hA1, 101'hAAA,  1);
    tbl[5]  = mk(1, 8'hB2, 101'hBBB,  0, 0, 1, 8'hA1, 101'hAAA,  0);
    tbl[6]  = mk(1, 8'hC3, 101'hCCC,  0, 0, 1, 8'hA1, 101'hAAA,  0);
    tbl[7]  = mk(1, 8'hC3, 101'hCCC,  0, 0, 1, 8'hA1, 101'hAAA,  0);
    tbl[8]  = mk(1, 8'hC3, 101'hCCC,  1, 0, 1, 8'hB2, 101'hBBB,  1);
    tbl[9]  = mk(1, 8'hC3, 101'hCCC,  1, 0, 1, 8'hC3, 101'hCCC,  1);
    tbl[10] = mk(0, 8'h00, 101'h0,    1, 0, 0, 8'h00, 101'h0,    1);
    tbl[11] = mk(1, 8'h11, 101'h111,  0, 0, 1, 8'h11, 101'h111,  1);
    tbl[12] = mk(1, 8'h22, 101'h222,  0, 0, 1, 8'h11, 101'h111,  0);
    tbl[13] = mk(1, 8'h33, 101'h333,  0, 1, 0, 8'h00, 101'h0,    1);
    tbl[14] = mk(0, 8'h00, 101'h0,    1, 0, 0, 8'h00, 101'h0,    1);
    tbl[15] = mk(1, 8'h44, 101'h444,  1, 1, 0, 8'h00, 101'h0,    1);
    tbl[16] = mk(0, 8'h00, 101'h0,    1, 0, 0, 8'h00, 101'h0,    1);
    tbl[17] = mk(0, 8'h00, 101'h0,    1, 0, 0, 8'h00, 101'h0,    1);

    up.valid = 1'b0;
    up.ctrl  = '0;
    up.data  = '0;
    dn.ready = 1'b0;
    flush    = 1'b0;
    rst      = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid",  128'(dn.valid),   128'(0));
    check("rst.out_ctrl",   128'(dn.ctrl),    128'(0));
    check("rst.out_data",   128'(dn.data),    128'(0));
    check("rst.in_ready",   128'(up.ready),   128'(1));
    check("rst.stall_cnt",  128'(stall_cnt),  128'(0));
    check("rst.bubble_cnt", 128'(bubble_cnt), 128'(0));
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      check($sformatf("vec%0d.out_valid", i), 128'(dn.valid), 128'(tbl[i].ev));
      check($sformatf("vec%0d.out_ctrl", i),  128'(dn.ctrl),  128'(tbl[i].ec));
      check($sformatf("vec%0d.in_ready", i),  128'(up.ready), 128'(tbl[i].erdy));
      if (tbl[i].ev) check($sformatf("vec%0d.out_data", i), 128'(dn.data), 128'(tbl[i].ed));
    end

    // Ten back-to-back entries with the downstream always ready: one out per cycle, in order.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, CTRL_W'(i + 1), DATA_W'(256 + i), 1'b1, 1'b0);
      check($sformatf("b2b%0d.out_valid", i), 128'(dn.valid), 128'(1));
      check($sformatf("b2b%0d.out_data", i),  128'(dn.data),  128'(256 + i));
      check($sformatf("b2b%0d.in_ready", i),  128'(up.ready), 128'(1));
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check_model("b2b_drain");

    // Asynchronous reset dropped mid-cycle while two entries are held.
    cycle(1'b1, 8'h5A, 101'h5A5A, 1'b0, 1'b0);
    cycle(1'b1, 8'h6B, 101'h6B6B, 1'b0, 1'b0);
    check("two.in_ready", 128'(up.ready), 128'(0));
    #2;
    rst = 1'b0;
    #1;
    check("arst.out_valid", 128'(dn.valid), 128'(0));
    check("arst.out_ctrl",  128'(dn.ctrl),  128'(0));
    check("arst.out_data",  128'(dn.data),  128'(0));
    check("arst.in_ready",  128'(up.ready), 128'(1));
    model_reset();
    #1;
    rst = 1'b1;

    // Two bubble cycles, one load, four stall cycles, then a flush that must not touch the counters.
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, 8'h3C, 101'h3C3C, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
`ifdef PIPE_STAGE_REG_PERF_EN
    check("perf.stall_cnt",  128'(stall_cnt),  128'(4));
    check("perf.bubble_cnt", 128'(bubble_cnt), 128'(2));
`else
    check("perf.stall_cnt",  128'(stall_cnt),  128'(0));
    check("perf.bubble_cnt", 128'(bubble_cnt), 128'(0));
`endif
    check_model("perf");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic v;
      logic ordy;
      logic fl;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      cycle(v, CTRL_W'($urandom), rnd_data(), ordy, fl);
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers, e.g. between the EX and MEM stages.
- Carries a control bundle and a data bundle between two pipeline stages using a valid/ready handshake.
- Includes a 2-entry skid buffer, so in_ready is driven from a register and back-pressure does not form a combinational path.
- Supports a synchronous flush for branch/exception squash, and forces control bits to zero on bubbles so downstream never sees a stale MemWrite/RegWrite.

Parameters:
- CTRL_W, 8: width of the control bundle (MemRead, MemWrite, MemtoReg, RegWrite, ...). Zeroed whenever the entry is not valid.
- DATA_W, 101: width of the data bundle (ALUOut, rt_data, WriteAddr, pc_plus_4, ...). Not cleared on bubble.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  register can accept an entry; registered output
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts the entry (stall = 0)
- out_ctrl  out  CTRL_W  main control bundle; all zero when out_valid=0
- out_data  out  DATA_W  main data bundle; contents unspecified when out_valid=0
- stall_cnt  out  CNT_W  optional, see below
- bubble_cnt  out  CNT_W  optional, see below

Behaviour:
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: a main register (out_*) and a skid register. State is encoded in main_v and skid_v.
- in_ready = !skid_v, registered. out_valid = main_v.
- Reset (rst=0, asynchronous):
  - main_v=0, skid_v=0, in_ready=1, out_valid=0, out_ctrl=0, out_data=0, skid contents=0, counters=0.
  - Deassertion of rst is taken synchronously; the first active edge after release behaves as state EMPTY.
- State machine, evaluated at each rising clock edge when flush=0:
  - EMPTY (main_v=0, skid_v=0):
    - in_fire -> ONE; main <= in.
  - ONE (main_v=1, skid_v=0):
    - in_fire & out_fire -> ONE; main <= in.
    - in_fire & !out_fire -> TWO; skid <= in, main held.
    - !in_fire & out_fire -> EMPTY.
    - neither -> hold.
  - TWO (main_v=1, skid_v=1; in_ready=0, so in_fire cannot occur):
    - out_fire -> ONE; main <= skid, skid_v <= 0.
    - otherwise hold.
- Latency and ordering:
  - 1 cycle from in_fire to out_valid when the register is empty.
  - Strict FIFO order; no entry is ever dropped or duplicated.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Flush:
  - Highest priority. At the edge where flush=1: main_v=0, skid_v=0, out_ctrl=0, and in_ready=1 on the next cycle.
  - An in_valid presented in the flush cycle is discarded, even if in_ready=1.
  - out_fire in the flush cycle is still a completed transfer for the downstream stage; the upstream stage treats it as squashed.
- Control gating: the ctrl field is written as 0 whenever the destination valid bit is 0, so out_ctrl==0 whenever out_valid==0.
- Data fields load only on their own fire events; no unnecessary toggling.
- Reset mid-operation: all held entries are lost immediately and outputs go to their reset values asynchronously.

Optional Feature:
- Macro: PIPE_STAGE_REG_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - bubble_cnt increments each cycle with out_valid=0 & out_ready=1.
  - Both counters saturate at all-ones, are cleared by reset, and are not cleared by flush.
- Undefined:
  - stall_cnt and bubble_cnt are tied to 0; no counter flops are synthesised.
  - Port list is unchanged.

Test Plan:
- Reset release, then in_valid=1, ctrl=0x05, data=0x1234 with out_ready=1 -> next cycle out_valid=1, out_ctrl=0x05, out_data=0x1234. Sustain 10 back-to-back entries -> 10 outputs in 10 cycles, same order.
- Stall: hold out_ready=0 and present A, B, C on consecutive cycles -> A in main, B in skid, in_ready=0 on the cycle after B is accepted, C held upstream. Release out_ready -> outputs A, B, C in order with no loss.
- Flush in state TWO with in_valid=1 -> next cycle out_valid=0, out_ctrl=0x00, in_ready=1; the flushed input never appears on the output.
- Bubble: in_valid=0 with out_ready=1 for 3 cycles after an entry drains -> out_ctrl=0x00 in all 3 cycles.
- Asynchronous reset asserted mid-clock in state TWO -> out_valid, out_ctrl and out_data go to 0 immediately without waiting for a clock edge.
- With PIPE_STAGE_REG_PERF_EN defined: 4 stall cycles and 2 bubble cycles -> stall_cnt=4, bubble_cnt=2; flush leaves both unchanged. Without the macro: both read 0.
